// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit seven-segment driver: prescaled digit scan,
// double-buffered display value, optional hex glyphs and leading-zero blanking.
module seven_seg_scan #(
   parameter int NUM_DIGITS    = 4,
   parameter int CLK_DIV       = 50000,
   parameter bit HEX_MODE      = 1'b0,
   parameter bit BLANK_LEADING = 1'b1,
   parameter int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic                    enable,
   output logic [6:0]              seven_seg,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [IDX_W-1:0]        digit_idx,
   output logic                    frame_start
);

   localparam int                    PW        = $clog2(CLK_DIV);
   localparam logic [PW-1:0]         PRE_LAST  = PW'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ANODE_ONE = NUM_DIGITS'(1);

   logic [PW-1:0]           prescaler;
   logic [IDX_W-1:0]        scan_idx;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [4*NUM_DIGITS-1:0] display;
   logic                    tick;
   logic                    wrap;
   logic [3:0]              cur_nib;
   logic                    cur_blank;
   logic                    zero_above;

   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'b0000001;
         4'h1:    g = 7'b1001111;
         4'h2:    g = 7'b0010010;
         4'h3:    g = 7'b0000110;
         4'h4:    g = 7'b1001100;
         4'h5:    g = 7'b0100100;
         4'h6:    g = 7'b0100000;
         4'h7:    g = 7'b0001111;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0000100;
         4'hA:    g = HEX_MODE ? 7'b0001000 : 7'b0000001;
         4'hB:    g = HEX_MODE ? 7'b1100000 : 7'b0000001;
         4'hC:    g = HEX_MODE ? 7'b0110001 : 7'b0000001;
         4'hD:    g = HEX_MODE ? 7'b1000010 : 7'b0000001;
         4'hE:    g = HEX_MODE ? 7'b0110000 : 7'b0000001;
         default: g = HEX_MODE ? 7'b0111000 : 7'b0000001;
      endcase
      return g;
   endfunction

   assign tick = enable && (prescaler == PRE_LAST);
   assign wrap = tick && (scan_idx == IDX_LAST);

   // Walk from the top digit down so zero_above covers this nibble and all higher ones.
   always_comb begin
      zero_above = 1'b1;
      cur_nib    = 4'd0;
      cur_blank  = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above & (display[4*i +: 4] == 4'd0);
         if (scan_idx == IDX_W'(i)) begin
            cur_nib   = display[4*i +: 4];
            cur_blank = BLANK_LEADING && (i > 0) && zero_above;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
         scan_idx  <= '0;
      end else if (enable) begin
         prescaler <= tick ? '0 : prescaler + PW'(1);
         if (tick)
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
      end
   end

   // Display only changes at the frame boundary; a coincident load bypasses the shadow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow  <= '0;
         display <= '0;
      end else begin
         if (load)
            shadow <= value;
         if (wrap)
            display <= load ? value : shadow;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seven_seg   <= 7'b1111111;
         anode       <= '1;
         digit_idx   <= '0;
         frame_start <= 1'b0;
      end else begin
         digit_idx   <= scan_idx;
         frame_start <= wrap;
         if (enable) begin
            anode     <= ~(ANODE_ONE << scan_idx);
            seven_seg <= cur_blank ? 7'b1111111 : decode(cur_nib);
         end else begin
            anode     <= '1;
            seven_seg <= 7'b1111111;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: 4-digit decimal, 4-digit hex and 1-digit
// instances share one stimulus set; each scenario task checks its own results.
module tb_seven_seg_scan;

   logic        clk;
   logic        reset;
   logic        load;
   logic        enable;
   logic [15:0] value;

   logic [6:0]  seg, seg_h, seg1;
   logic [3:0]  anode, anode_h;
   logic [1:0]  idx, idx_h;
   logic [0:0]  anode1, idx1;
   logic        fs, fs_h, fs1;

   int checks   = 0;
   int failures = 0;

   localparam logic [3:0] AN_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   localparam logic [6:0] BLANK = 7'b1111111;

   seven_seg_scan #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(1'b0), .BLANK_LEADING(1'b1)) dut (
      .clk(clk), .reset(reset), .value(value), .load(load), .enable(enable),
      .seven_seg(seg), .anode(anode), .digit_idx(idx), .frame_start(fs));

   seven_seg_scan #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(1'b1), .BLANK_LEADING(1'b1)) dut_hex (
      .clk(clk), .reset(reset), .value(value), .load(load), .enable(enable),
      .seven_seg(seg_h), .anode(anode_h), .digit_idx(idx_h), .frame_start(fs_h));

   seven_seg_scan #(.NUM_DIGITS(1), .CLK_DIV(2), .HEX_MODE(1'b0), .BLANK_LEADING(1'b1)) dut1 (
      .clk(clk), .reset(reset), .value(value[3:0]), .load(load), .enable(enable),
      .seven_seg(seg1), .anode(anode1), .digit_idx(idx1), .frame_start(fs1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_frame(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (fs === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic load_value(input logic [15:0] v);
      value = v;
      load  = 1'b1;
      step(1);
      load  = 1'b0;
   endtask

   task automatic test_reset;
      step(2);
      checks++; if (anode !== 4'b1111) begin failures++; $display("FAIL reset_anode: got %b expected 1111", anode); end
      checks++; if (seg !== BLANK) begin failures++; $display("FAIL reset_seg: got %b expected %b", seg, BLANK); end
      checks++; if (idx !== 2'd0) begin failures++; $display("FAIL reset_idx: got %0d expected 0", idx); end
      checks++; if (fs !== 1'b0) begin failures++; $display("FAIL reset_fs: got %b expected 0", fs); end
      checks++; if (anode1 !== 1'b1) begin failures++; $display("FAIL reset_anode1: got %b expected 1", anode1); end
      reset = 1'b0;
      step(1);
      checks++; if (anode !== 4'b1110) begin failures++; $display("FAIL post_reset_anode: got %b expected 1110", anode); end
      checks++; if (seg !== 7'b0000001) begin failures++; $display("FAIL post_reset_seg: got %b expected 0000001", seg); end
   endtask

   task automatic test_scan;
      logic [6:0] exp_seg [4];
      bit ok;
      int d;
      exp_seg = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
      load_value(16'h1234);
      wait_frame(ok);
      checks++; if (!ok) begin failures++; $display("FAIL scan_sync: got no frame_start expected one within 100 cycles"); end
      for (int i = 0; i < 16; i++) begin
         d = i / 4;
         step(1);
         checks++; if (anode !== AN_TAB[d]) begin failures++; $display("FAIL scan_anode[%0d]: got %b expected %b", i, anode, AN_TAB[d]); end
         checks++; if (seg !== exp_seg[d]) begin failures++; $display("FAIL scan_seg[%0d]: got %b expected %b", i, seg, exp_seg[d]); end
         checks++; if (idx !== 2'(d)) begin failures++; $display("FAIL scan_idx[%0d]: got %0d expected %0d", i, idx, d); end
         checks++; if (fs !== (i == 15)) begin failures++; $display("FAIL scan_fs[%0d]: got %b expected %b", i, fs, (i == 15)); end
      end
   endtask

   task automatic test_double_buffer;
      logic [6:0] exp_seg [3][4];
      int d;
      exp_seg[0] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
      exp_seg[1] = '{7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100};
      exp_seg[2] = '{7'b0000100, BLANK, BLANK, BLANK};
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 16; i++) begin
            d = i / 4;
            step(1);
            checks++; if (anode !== AN_TAB[d]) begin failures++; $display("FAIL dbuf_anode[%0d][%0d]: got %b expected %b", f, i, anode, AN_TAB[d]); end
            checks++; if (seg !== exp_seg[f][d]) begin failures++; $display("FAIL dbuf_seg[%0d][%0d]: got %b expected %b", f, i, seg, exp_seg[f][d]); end
            checks++; if (fs !== (i == 15)) begin failures++; $display("FAIL dbuf_fs[%0d][%0d]: got %b expected %b", f, i, fs, (i == 15)); end
            load = 1'b0;
            if (f == 0 && i == 1) begin
               value = 16'h5678;
               load  = 1'b1;
            end
            if (f == 1 && i == 14) begin
               value = 16'h0009;
               load  = 1'b1;
            end
         end
      end
      load = 1'b0;
   endtask

   task automatic test_hex;
      logic [6:0] exp_dec [4];
      logic [6:0] exp_hex [4];
      bit ok;
      int d;
      exp_dec = '{7'b0000001, 7'b0000001, BLANK, BLANK};
      exp_hex = '{7'b0000001, 7'b0001000, BLANK, BLANK};
      load_value(16'h00A0);
      wait_frame(ok);
      checks++; if (!ok) begin failures++; $display("FAIL hex_sync: got no frame_start expected one within 100 cycles"); end
      for (int i = 0; i < 16; i++) begin
         d = i / 4;
         step(1);
         checks++; if (seg !== exp_dec[d]) begin failures++; $display("FAIL dec_seg[%0d]: got %b expected %b", i, seg, exp_dec[d]); end
         checks++; if (seg_h !== exp_hex[d]) begin failures++; $display("FAIL hex_seg[%0d]: got %b expected %b", i, seg_h, exp_hex[d]); end
         checks++; if (anode_h !== AN_TAB[d]) begin failures++; $display("FAIL hex_anode[%0d]: got %b expected %b", i, anode_h, AN_TAB[d]); end
         checks++; if (idx_h !== 2'(d)) begin failures++; $display("FAIL hex_idx[%0d]: got %0d expected %0d", i, idx_h, d); end
         checks++; if (fs_h !== (i == 15)) begin failures++; $display("FAIL hex_fs[%0d]: got %b expected %b", i, fs_h, (i == 15)); end
      end
   endtask

   task automatic test_enable;
      bit ok;
      int d;
      load_value(16'h1234);
      wait_frame(ok);
      checks++; if (!ok) begin failures++; $display("FAIL en_sync: got no frame_start expected one within 100 cycles"); end
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (i >= 8) begin
            checks++; if (anode !== 4'b1011) begin failures++; $display("FAIL en_pre_anode[%0d]: got %b expected 1011", i, anode); end
            checks++; if (seg !== 7'b0010010) begin failures++; $display("FAIL en_pre_seg[%0d]: got %b expected 0010010", i, seg); end
         end
      end
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         checks++; if (anode !== 4'b1111) begin failures++; $display("FAIL en_off_anode[%0d]: got %b expected 1111", i, anode); end
         checks++; if (seg !== BLANK) begin failures++; $display("FAIL en_off_seg[%0d]: got %b expected %b", i, seg, BLANK); end
         checks++; if (idx !== 2'd2) begin failures++; $display("FAIL en_off_idx[%0d]: got %0d expected 2", i, idx); end
         checks++; if (fs !== 1'b0) begin failures++; $display("FAIL en_off_fs[%0d]: got %b expected 0", i, fs); end
      end
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         d = (i < 2) ? 2 : 3;
         step(1);
         checks++; if (anode !== AN_TAB[d]) begin failures++; $display("FAIL en_resume_anode[%0d]: got %b expected %b", i, anode, AN_TAB[d]); end
         checks++; if (seg !== ((d == 2) ? 7'b0010010 : 7'b1001111)) begin failures++; $display("FAIL en_resume_seg[%0d]: got %b for digit %0d", i, seg, d); end
         checks++; if (fs !== (i == 5)) begin failures++; $display("FAIL en_resume_fs[%0d]: got %b expected %b", i, fs, (i == 5)); end
      end
   endtask

   task automatic test_single_digit;
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (fs1 === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++; if (!ok) begin failures++; $display("FAIL single_sync: got no frame_start expected one within 10 cycles"); end
      for (int i = 0; i < 8; i++) begin
         step(1);
         checks++; if (anode1 !== 1'b0) begin failures++; $display("FAIL single_anode[%0d]: got %b expected 0", i, anode1); end
         checks++; if (idx1 !== 1'b0) begin failures++; $display("FAIL single_idx[%0d]: got %0d expected 0", i, idx1); end
         checks++; if (fs1 !== (i % 2 == 1)) begin failures++; $display("FAIL single_fs[%0d]: got %b expected %b", i, fs1, (i % 2 == 1)); end
         checks++; if (seg1 !== 7'b1001100) begin failures++; $display("FAIL single_seg[%0d]: got %b expected 1001100", i, seg1); end
      end
   endtask

   task automatic test_reset_mid_scan;
      bit ok;
      wait_frame(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rst_sync: got no frame_start expected one within 100 cycles"); end
      step(5);
      checks++; if (idx !== 2'd1) begin failures++; $display("FAIL rst_pre_idx: got %0d expected 1", idx); end
      #3 reset = 1'b1;
      #1;
      checks++; if (anode !== 4'b1111) begin failures++; $display("FAIL rst_mid_anode: got %b expected 1111", anode); end
      checks++; if (seg !== BLANK) begin failures++; $display("FAIL rst_mid_seg: got %b expected %b", seg, BLANK); end
      checks++; if (idx !== 2'd0) begin failures++; $display("FAIL rst_mid_idx: got %0d expected 0", idx); end
      checks++; if (anode1 !== 1'b1) begin failures++; $display("FAIL rst_mid_anode1: got %b expected 1", anode1); end
      step(1);
      reset = 1'b0;
      step(1);
      checks++; if (anode !== 4'b1110) begin failures++; $display("FAIL rst_restart_anode: got %b expected 1110", anode); end
      checks++; if (seg !== 7'b0000001) begin failures++; $display("FAIL rst_restart_seg: got %b expected 0000001", seg); end
      wait_frame(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rst_frame: got no frame_start expected one within 100 cycles"); end
      step(1);
      checks++; if (seg !== 7'b0000001) begin failures++; $display("FAIL rst_shadow_seg: got %b expected 0000001", seg); end
   endtask

   initial begin
      reset  = 1'b1;
      load   = 1'b0;
      enable = 1'b1;
      value  = 16'h0000;
      test_reset();
      test_scan();
      test_double_buffer();
      test_hex();
      test_enable();
      test_single_digit();
      test_reset_mid_scan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
